// File: rtl/arm_code_emitter_if.sv
// Handshake/bus bundle between the translation state machine, the code
// emitter and the output code RAM. ADDR_W must match the emitter instance.
interface arm_code_emitter_if #(
  parameter int unsigned ADDR_W = 10
);
  // State machine side
  logic              in_valid;
  logic [31:0]       in_word;
  logic              in_patch;
  logic              param_valid;
  logic [7:0]        param_byte;
  logic              param_clear;
  logic              flush;
  logic              waiting;
  // Code RAM side
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  // Status
  logic [ADDR_W:0]   code_len;
  logic              done;
  logic              overflow;
  logic              imm_err;

  modport master (
    output in_valid, in_word, in_patch, param_valid, param_byte, param_clear, flush,
    output mem_ready,
    input  waiting, mem_we, mem_addr, mem_wdata, code_len, done, overflow, imm_err
  );

  modport slave (
    input  in_valid, in_word, in_patch, param_valid, param_byte, param_clear, flush,
    input  mem_ready,
    output waiting, mem_we, mem_addr, mem_wdata, code_len, done, overflow, imm_err
  );
endinterface

// File: rtl/arm_code_emitter.sv
// ARM code emitter: patches JVM operand immediates into ARM instruction
// templates, buffers them in a small FIFO and streams them into the code RAM.
// Optional feature: define ARM_EMIT_TERMINATOR_EN to append BX LR after flush.
module arm_code_emitter #(
  parameter int unsigned FIFO_DEPTH = 8,   // power of two, >= 2
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic               clk,
  input logic               reset,         // asynchronous, active-low
  arm_code_emitter_if.slave bus
);

  localparam int unsigned       PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned       CntW     = PtrW + 1;
  localparam logic [CntW-1:0]   CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] AddrMax  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);
`ifdef ARM_EMIT_TERMINATOR_EN
  localparam logic [31:0]       BxLr     = 32'hE12FFF1E;
`endif

`ifdef ARM_EMIT_TERMINATOR_EN
  typedef enum logic [2:0] {StIdle, StWrite, StDrainEnd, StTerm, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWrite, StDrainEnd, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [15:0]       imm_q, imm_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]       fifo_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   code_len_q, code_len_d;
  logic              overflow_q, overflow_d;
  logic              imm_err_q, imm_err_d;
  logic              flush_pend_q, flush_pend_d;
`ifdef ARM_EMIT_TERMINATOR_EN
  logic              wrap_q, wrap_d;
`endif

  logic        waiting;
  logic        push, pop;
  logic        active;
  logic [31:0] push_word;

  // Stall request: FIFO full, writer busy with end-of-stream, or flush seen.
  always_comb begin
    waiting = (count_q == CntFull) | (state_q != StIdle && state_q != StWrite) | flush_pend_q;
  end

  // Datapath next-state: immediate accumulator, FIFO, sticky error flags.
  always_comb begin
    active       = (state_q != StDone);
    push         = bus.in_valid & ~waiting;
    push_word    = bus.in_patch ? {bus.in_word[31:12], imm_q[11:0]} : bus.in_word;
    imm_d        = imm_q;
    fifo_d       = fifo_q;
    tail_d       = tail_q;
    imm_err_d    = imm_err_q;
    flush_pend_d = flush_pend_q;
    if (active) begin
      if (bus.param_valid && bus.param_clear) begin
        imm_d = {8'h00, bus.param_byte};
      end else if (bus.param_clear) begin
        imm_d = 16'h0000;
      end else if (bus.param_valid) begin
        imm_d = {imm_q[7:0], bus.param_byte};
      end
      if (bus.flush) flush_pend_d = 1'b1;
    end
    if (push) begin
      fifo_d[tail_q] = push_word;
      tail_d         = tail_q + 1'b1;
      // Immediate wider than 12 bits is truncated but flagged.
      if (bus.in_patch && (|imm_q[15:12])) imm_err_d = 1'b1;
    end
  end

  // Writer FSM next-state and RAM write port.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    waddr_d     = waddr_q;
    code_len_d  = code_len_q;
    overflow_d  = overflow_q;
    pop         = 1'b0;
`ifdef ARM_EMIT_TERMINATOR_EN
    wrap_d      = wrap_q;
`endif
    // A word offered while stalled is lost.
    if (bus.in_valid && waiting && active) overflow_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = waddr_q;
          mem_wdata_d = fifo_q[head_q];
          state_d     = StWrite;
        end else if (flush_pend_q) begin
          state_d = StDrainEnd;
        end
      end
      StWrite: begin
        if (bus.mem_ready) begin
          mem_we_d   = 1'b0;
          pop        = 1'b1;
          waddr_d    = waddr_q + 1'b1;
          code_len_d = code_len_q + 1'b1;
          if (mem_addr_q == AddrMax) begin
            // Code RAM exhausted: stop, leftover FIFO words are abandoned.
            overflow_d = 1'b1;
            state_d    = StDone;
`ifdef ARM_EMIT_TERMINATOR_EN
            wrap_d     = 1'b1;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrainEnd: begin
`ifdef ARM_EMIT_TERMINATOR_EN
        if (wrap_q) begin
          overflow_d = 1'b1;
          state_d    = StDone;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = waddr_q;
          mem_wdata_d = BxLr;
          state_d     = StTerm;
        end
`else
        state_d = StDone;
`endif
      end
`ifdef ARM_EMIT_TERMINATOR_EN
      StTerm: begin
        if (bus.mem_ready) begin
          mem_we_d   = 1'b0;
          waddr_d    = waddr_q + 1'b1;
          code_len_d = code_len_q + 1'b1;
          state_d    = StDone;
        end
      end
`endif
      StDone: ;
      default: state_d = StIdle;
    endcase
    head_d  = pop ? head_q + 1'b1 : head_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      imm_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      waddr_q      <= AddrBase;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      code_len_q   <= '0;
      overflow_q   <= 1'b0;
      imm_err_q    <= 1'b0;
      flush_pend_q <= 1'b0;
`ifdef ARM_EMIT_TERMINATOR_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      imm_q        <= imm_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      waddr_q      <= waddr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      code_len_q   <= code_len_d;
      overflow_q   <= overflow_d;
      imm_err_q    <= imm_err_d;
      flush_pend_q <= flush_pend_d;
`ifdef ARM_EMIT_TERMINATOR_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

  // FIFO storage: data only, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.waiting   = waiting;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.code_len  = code_len_q;
  assign bus.done      = (state_q == StDone);
  assign bus.overflow  = overflow_q;
  assign bus.imm_err   = imm_err_q;

endmodule

// File: tb/tb_arm_code_emitter.sv
// Directed testbench for arm_code_emitter: a default-size instance and an
// ADDR_W=2 instance for address-space exhaustion.
module tb_arm_code_emitter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arm_code_emitter_if #(.ADDR_W(10)) bus ();
  arm_code_emitter_if #(.ADDR_W(2))  bus_s ();

  arm_code_emitter #(.FIFO_DEPTH(8), .ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  arm_code_emitter #(.FIFO_DEPTH(8), .ADDR_W(2), .BASE_ADDR(0)) u_dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_addr_s [$];
  logic [31:0] wr_data_s [$];

  // Record every accepted RAM write (mem_ready is stable between edges).
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      wr_addr.push_back(int'(bus.mem_addr));
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus_s.mem_we && bus_s.mem_ready) begin
      wr_addr_s.push_back(int'(bus_s.mem_addr));
      wr_data_s.push_back(bus_s.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input logic ready);
    bus.in_valid    = 1'b0;  bus_s.in_valid    = 1'b0;
    bus.in_word     = '0;    bus_s.in_word     = '0;
    bus.in_patch    = 1'b0;  bus_s.in_patch    = 1'b0;
    bus.param_valid = 1'b0;  bus_s.param_valid = 1'b0;
    bus.param_byte  = '0;    bus_s.param_byte  = '0;
    bus.param_clear = 1'b0;  bus_s.param_clear = 1'b0;
    bus.flush       = 1'b0;  bus_s.flush       = 1'b0;
    bus.mem_ready   = ready; bus_s.mem_ready   = ready;
  endtask

  task automatic do_reset(input logic ready);
    idle_inputs(ready);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_addr.delete(); wr_data.delete();
    wr_addr_s.delete(); wr_data_s.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] w, input logic patch);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_patch = patch;
    tick();
    bus.in_valid = 1'b0;
    bus.in_patch = 1'b0;
  endtask

  task automatic param(input logic [7:0] b, input logic clr);
    bus.param_valid = 1'b1;
    bus.param_byte  = b;
    bus.param_clear = clr;
    tick();
    bus.param_valid = 1'b0;
    bus.param_clear = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && wr_data.size() < n; i++) tick();
    check(tag, 64'(wr_data.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_exp;
    idle_inputs(1'b1);
    #12;
    // Outputs while held in reset.
    check("rst_outputs",
          {bus.mem_we, bus.waiting, bus.done, bus.overflow, bus.imm_err, bus.code_len},
          64'h0);
    check("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    do_reset(1'b1);

    // Unpatched push: mem_we appears two edges after the push edge.
    push(32'hE3A00000, 1'b0);
    check("lat_e1_we", bus.mem_we, 1'b0);
    tick();
    check("lat_e2_we", bus.mem_we, 1'b1);
    check("lat_e2_addr", bus.mem_addr, 10'd0);
    check("lat_e2_data", bus.mem_wdata, 32'hE3A00000);
    tick();
    check("first_code_len", bus.code_len, 11'd1);
    check("first_we_drop", bus.mem_we, 1'b0);

    // Patched push with imm = 0x012C.
    param(8'h01, 1'b0);
    param(8'h2C, 1'b0);
    push(32'hE3A01000, 1'b1);
    wait_writes(2, 20, "patch1_cnt");
    check("patch1_addr", 64'(wr_addr[1]), 64'd1);
    check("patch1_data", wr_data[1], 32'hE3A0112C);
    check("patch1_imm_err", bus.imm_err, 1'b0);

    // imm = 0x1234: truncated to 0x234 and flagged.
    param(8'h12, 1'b0);
    param(8'h34, 1'b0);
    push(32'hE3A01000, 1'b1);
    wait_writes(3, 20, "patch2_cnt");
    check("patch2_data", wr_data[2], 32'hE3A01234);
    check("patch2_imm_err", bus.imm_err, 1'b1);

    // Clear and load in the same cycle yields 0x0005.
    param(8'h05, 1'b1);
    push(32'hE3A01ABC, 1'b1);
    wait_writes(4, 20, "clrld_cnt");
    check("clrld_addr", 64'(wr_addr[3]), 64'd3);
    check("clrld_data", wr_data[3], 32'hE3A01005);

    // Fill the FIFO with the RAM stalled, then overflow with a ninth word.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = 32'hA0000000 + 32'(i);
      tick();
      if (i == 6) check("fill7_waiting", bus.waiting, 1'b0);
    end
    check("full_waiting", bus.waiting, 1'b1);
    check("full_no_ovf", bus.overflow, 1'b0);
    bus.in_word = 32'hDEADBEEF;
    tick();
    bus.in_valid = 1'b0;
    check("ninth_ovf", bus.overflow, 1'b1);
    bus.mem_ready = 1'b1;
    wait_writes(8, 60, "drain8_cnt");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain8_addr%0d", i), 64'(wr_addr[i]), 64'(i));
      check($sformatf("drain8_data%0d", i), wr_data[i], 32'hA0000000 + 32'(i));
    end
    tick(4);
    check("drain8_no_extra", 64'(wr_data.size()), 64'd8);
    check("drain8_code_len", bus.code_len, 11'd8);

    // Flush with the last push in the same cycle.
    do_reset(1'b1);
    push(32'hB0000000, 1'b0);
    push(32'hB0000001, 1'b0);
    bus.flush = 1'b1;
    push(32'hB0000002, 1'b0);
    bus.flush = 1'b0;
    check("flush_waiting", bus.waiting, 1'b1);
    for (int i = 0; i < 60 && !bus.done; i++) tick();
    check("flush_done", bus.done, 1'b1);
`ifdef ARM_EMIT_TERMINATOR_EN
    n_exp = 4;
`else
    n_exp = 3;
`endif
    check("flush_wr_cnt", 64'(wr_data.size()), 64'(n_exp));
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      check($sformatf("flush_data%0d", i), wr_data[i], 32'hB0000000 + 32'(i));
    end
`ifdef ARM_EMIT_TERMINATOR_EN
    if (wr_data.size() == 4) begin
      check("term_addr", 64'(wr_addr[3]), 64'd3);
      check("term_data", wr_data[3], 32'hE12FFF1E);
    end
`endif
    check("flush_code_len", bus.code_len, 11'(n_exp));
    check("done_waiting", bus.waiting, 1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("done_ignores_in", bus.overflow, 1'b0);

    // ADDR_W = 2: only four addresses exist.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      bus_s.in_valid = 1'b1;
      bus_s.in_word  = 32'hC0000000 + 32'(i);
      tick();
    end
    bus_s.in_valid = 1'b0;
    for (int i = 0; i < 60 && !bus_s.done; i++) tick();
    tick(3);
    check("small_wr_cnt", 64'(wr_data_s.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_data_s.size(); i++) begin
      check($sformatf("small_addr%0d", i), 64'(wr_addr_s[i]), 64'(i));
      check($sformatf("small_data%0d", i), wr_data_s[i], 32'hC0000000 + 32'(i));
    end
    check("small_ovf", bus_s.overflow, 1'b1);
    check("small_done", bus_s.done, 1'b1);
    check("small_code_len", bus_s.code_len, 3'd4);

    // Asynchronous reset in the middle of a stalled write.
    do_reset(1'b1);
    push(32'h11111111, 1'b0);
    wait_writes(1, 20, "arst_pre_cnt");
    bus.mem_ready = 1'b0;
    push(32'h22222222, 1'b0);
    tick();
    check("arst_we_before", bus.mem_we, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_we", bus.mem_we, 1'b0);
    check("arst_status",
          {bus.waiting, bus.done, bus.overflow, bus.imm_err, bus.code_len}, 64'h0);
    check("arst_addr_data", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_code_emitter.md
Name: arm_code_emitter

Overview:
- Downstream of the translation state machine; consumes the ARM instruction words selected by its ROM address stream, plus the JVM operand bytes it steps through during parameter fetch.
- Patches operand immediates into instruction templates and buffers words in a small FIFO.
- Writes buffered words sequentially into the output code RAM through a ready handshake.
- Drives `waiting` back to the state machine to stall translation when the FIFO cannot accept a word or a flush is in progress.

Parameters:
- FIFO_DEPTH, 8, buffered instruction words; power of two, ≥2.
- ADDR_W, 10, code RAM word-address width.
- BASE_ADDR, 0, first code RAM word address written after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  instruction word offered this cycle.
- in_word  in  32  ARM instruction template.
- in_patch  in  1  replace in_word[11:0] with the accumulated immediate.
- param_valid  in  1  operand byte present.
- param_byte  in  8  JVM operand byte, big-endian order.
- param_clear  in  1  zero the immediate accumulator.
- flush  in  1  end of bytecode stream; single-cycle pulse.
- mem_ready  in  1  code RAM accepted the current write.
- waiting  out  1  stall request to the state machine.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- code_len  out  ADDR_W+1  words committed to RAM.
- done  out  1  flush complete.
- overflow  out  1  sticky: push while full, or code RAM exhausted.
- imm_err  out  1  sticky: patched immediate exceeded 12 bits.

Behaviour:
- Reset values: all outputs 0; FIFO empty; imm = 0; write pointer = BASE_ADDR; FSM in IDLE. Reset mid-write drops mem_we immediately, with no completion.
- Immediate accumulator: imm[15:0].
  - param_valid: imm <= {imm[7:0], param_byte}.
  - param_clear: imm <= 0.
  - Both in the same cycle: imm <= {8'h00, param_byte}.
- Push: occurs when in_valid & !waiting.
  - Stored word is in_patch ? {in_word[31:12], imm[11:0]} : in_word.
  - Patching uses imm as registered before any same-cycle param update.
  - If in_patch & |imm[15:12], imm_err is set; the truncated word is still stored.
- waiting is combinational: (count == FIFO_DEPTH) | (state != IDLE && state != WRITE) | flush_pending.
  - in_valid while waiting = 1 sets overflow and drops the word.
- Pop: occurs on a clock edge where mem_we & mem_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full blocks a push even if a pop occurs that cycle; there is no look-ahead.
- Writer FSM:
  - IDLE: if FIFO non-empty, load mem_wdata from the FIFO head and mem_addr from the write pointer, assert mem_we, go to WRITE. Else if flush_pending, go to DRAIN_END.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ready is sampled high. On acceptance: pop, increment the write pointer and code_len, then go to IDLE.
    - If the accepted address was 2^ADDR_W-1, set overflow and go to DONE; the remaining FIFO contents are discarded.
    - Minimum cost is one word per 2 cycles.
  - DRAIN_END: go to TERM (feature enabled) or DONE.
  - TERM: see Optional Feature.
  - DONE: done = 1, waiting = 1. All further inputs are ignored until reset.
- flush:
  - Sets flush_pending and raises waiting from the next cycle.
  - A push in the flush cycle is still accepted.
  - Remaining FIFO words drain in order.
- Latency: a push into an empty FIFO in IDLE gives mem_we = 1 two cycles later; the word is registered into the FIFO first.

Optional Feature:
- Macro: ARM_EMIT_TERMINATOR_EN.
- Defined: after the drain, TERM writes 32'hE12FFF1E (BX LR) at the next address with the same handshake. code_len counts it, then the FSM goes to DONE. If the address space is already exhausted, overflow is set and no write is made.
- Undefined: the TERM state is absent; DRAIN_END goes directly to DONE.

Test Plan:
- Reset, mem_ready = 1. Push 32'hE3A00000 unpatched. Expect mem_we at cycle +2 with mem_addr = 0 and mem_wdata = E3A00000; code_len = 1.
- Params 8'h01 then 8'h2C, push 32'hE3A01000 with in_patch. Expect mem_wdata = E3A0112C and imm_err = 0. Repeat with imm = 16'h1234: stored word is low 12 = 234 and imm_err = 1.
- mem_ready = 0, push 8 words. Expect waiting = 1 at count 8; a ninth in_valid sets overflow. Raise mem_ready: all 8 words written in order at addresses 0..7.
- param_clear and param_valid (8'h05) in the same cycle, then a patched push. Expect low 12 bits = 005.
- Push 3 words, then pulse flush. Expect 3 writes, then BX LR at address 3 when the feature is enabled; done = 1, code_len = 4 (3 when disabled), and waiting held high.
- ADDR_W = 2, push 5 words. Expect 4 writes, overflow = 1, done = 1. Separately, assert reset while mem_we = 1: mem_we drops asynchronously and all outputs return to 0.
